axi_sram_slave: RTL and testbench

- Synthesizable AXI3 slave memory: the responder end of the DMA engine's AXI master ports (AW/W/B write path, AR/R read path).
- Used as the on-chip target for DMAC bring-up, and as an RTL replacement for the behavioural memory model.
- Write and read paths are independent FSMs. Each path has one outstanding burst.
- Word-addressed flop/SRAM array; supports backdoor-free reset and errors on out-of-range accesses.

---
 rtl/axi_sram_slave.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//   AXI3 slave memory used as the responder for the DMA engine's master
//   ports. The write path (AW/W/B) and the read path (AR/R) are independent
//   FSMs, and each path has one outstanding burst. Storage is a word-addressed
//   array of DEPTH 32-bit words. Any beat whose word index is >= DEPTH gets a
//   SLVERR response. Memory contents are never reset.
//
// Parameters
//   DEPTH : number of 32-bit words (power of 2)
//   ID_W  : width of AXI ID fields
//
// Ports
//   clk, rst_n      : clock; reset is asynchronous and ACTIVE-HIGH despite its name
//   aw*_i / awready_o : write address channel
//   w*_i  / wready_o  : write data channel (wid_i is ignored)
//   b*_o  / bready_i  : write response channel
//   ar*_i / arready_o : read address channel
//   r*_o  / rready_i  : read data channel
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int DEPTH = 4096,
    parameter int ID_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ID_W-1:0] awid_i,
    input  logic [31:0]     awaddr_i,
    input  logic [3:0]      awlen_i,
    input  logic [2:0]      awsize_i,
    input  logic [1:0]      awburst_i,
    input  logic            awvalid_i,
    output logic            awready_o,
    input  logic [ID_W-1:0] wid_i,
    input  logic [31:0]     wdata_i,
    input  logic [3:0]      wstrb_i,
    input  logic            wlast_i,
    input  logic            wvalid_i,
    output logic            wready_o,
    output logic [ID_W-1:0] bid_o,
    output logic [1:0]      bresp_o,
    output logic            bvalid_o,
    input  logic            bready_i,
    input  logic [ID_W-1:0] arid_i,
    input  logic [31:0]     araddr_i,
    input  logic [3:0]      arlen_i,
    input  logic [2:0]      arsize_i,
    input  logic [1:0]      arburst_i,
    input  logic            arvalid_i,
    output logic            arready_o,
    output logic [ID_W-1:0] rid_o,
    output logic [31:0]     rdata_o,
    output logic [1:0]      rresp_o,
    output logic            rlast_o,
    output logic            rvalid_o,
    input  logic            rready_i
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} rstate_t;

    logic [31:0] mem [DEPTH];

    // Word indices are the full 30-bit addr[31:2]; no modulo aliasing.
    function automatic logic in_range(input logic [29:0] idx);
        return {2'b00, idx} < 32'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] slot(input logic [29:0] idx);
        return idx[IDX_W-1:0];
    endfunction

    // Write path state
    wstate_t         wstate, wstate_d;
    logic [ID_W-1:0] wid_q, wid_d;
    logic [29:0]     waddr, waddr_d;
    logic [3:0]      wlen, wlen_d, wcnt, wcnt_d;
    logic            wfixed, wfixed_d, werr, werr_d;
    logic            awready_d, wready_d, bvalid_d, wbeat_last, mem_we;
    logic [ID_W-1:0] bid_d;
    logic [1:0]      bresp_d;

    // Read path state
    rstate_t         rstate, rstate_d;
    logic [29:0]     raddr, raddr_d, rd_addr;
    logic [3:0]      rlen, rlen_d, rcnt, rcnt_d;
    logic            rfixed, rfixed_d, rbad, rbad_d, rd_bad, rd_load;
    logic            arready_d, rvalid_d, rlast_d;
    logic [ID_W-1:0] rid_d;
    logic [1:0]      rresp_d;

    logic unused_bits;
    assign unused_bits = ^{wid_i, awaddr_i[1:0], araddr_i[1:0]};

    always_comb begin
        wstate_d   = wstate;
        wid_d      = wid_q;
        waddr_d    = waddr;
        wlen_d     = wlen;
        wfixed_d   = wfixed;
        werr_d     = werr;
        wcnt_d     = wcnt;
        awready_d  = awready_o;
        wready_d   = wready_o;
        bvalid_d   = bvalid_o;
        bid_d      = bid_o;
        bresp_d    = bresp_o;
        mem_we     = 1'b0;
        wbeat_last = (wcnt == wlen);
        case (wstate)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid_i && awready_o) begin
                    wid_d     = awid_i;
                    waddr_d   = awaddr_i[31:2];
                    wlen_d    = awlen_i;
                    wfixed_d  = (awburst_i == 2'b00);
                    werr_d    = (awsize_i != 3'b010);
                    wcnt_d    = 4'd0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid_i && wready_o) begin
                    mem_we  = in_range(waddr);
                    werr_d  = werr | (wlast_i != wbeat_last) | !in_range(waddr);
                    waddr_d = wfixed ? waddr : waddr + 30'd1;
                    wcnt_d  = wcnt + 4'd1;
                    // The burst length, not wlast, decides where the burst ends.
                    if (wbeat_last) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = wid_q;
                        bresp_d  = werr_d ? 2'b10 : 2'b00;
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_o && bready_i) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d  = rstate;
        raddr_d   = raddr;
        rlen_d    = rlen;
        rfixed_d  = rfixed;
        rbad_d    = rbad;
        rcnt_d    = rcnt;
        arready_d = arready_o;
        rvalid_d  = rvalid_o;
        rlast_d   = rlast_o;
        rid_d     = rid_o;
        rd_load   = 1'b0;
        rd_addr   = raddr;
        rd_bad    = rbad;
        case (rstate)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid_i && arready_o) begin
                    raddr_d   = araddr_i[31:2];
                    rlen_d    = arlen_i;
                    rfixed_d  = (arburst_i == 2'b00);
                    rbad_d    = (arsize_i != 3'b010);
                    rcnt_d    = 4'd0;
                    rid_d     = arid_i;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (arlen_i == 4'd0);
                    rd_load   = 1'b1;
                    rd_addr   = araddr_i[31:2];
                    rd_bad    = (arsize_i != 3'b010);
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_o && rready_i) begin
                    if (rlast_o) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        rstate_d  = R_IDLE;
                    end else begin
                        raddr_d = rfixed ? raddr : raddr + 30'd1;
                        rcnt_d  = rcnt + 4'd1;
                        rlast_d = ((rcnt + 4'd1) == rlen);
                        rd_load = 1'b1;
                        rd_addr = raddr_d;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        rresp_d = rresp_o;
        if (rd_load) rresp_d = (!in_range(rd_addr) || rd_bad) ? 2'b10 : 2'b00;
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wstate    <= W_IDLE;
            rstate    <= R_IDLE;
            wcnt      <= 4'd0;
            werr      <= 1'b0;
            rcnt      <= 4'd0;
            awready_o <= 1'b0;
            wready_o  <= 1'b0;
            bvalid_o  <= 1'b0;
            bid_o     <= '0;
            bresp_o   <= 2'b00;
            arready_o <= 1'b0;
            rvalid_o  <= 1'b0;
            rlast_o   <= 1'b0;
            rid_o     <= '0;
            rresp_o   <= 2'b00;
            rdata_o   <= 32'd0;
        end else begin
            wstate    <= wstate_d;
            rstate    <= rstate_d;
            wcnt      <= wcnt_d;
            werr      <= werr_d;
            rcnt      <= rcnt_d;
            awready_o <= awready_d;
            wready_o  <= wready_d;
            bvalid_o  <= bvalid_d;
            bid_o     <= bid_d;
            bresp_o   <= bresp_d;
            arready_o <= arready_d;
            rvalid_o  <= rvalid_d;
            rlast_o   <= rlast_d;
            rid_o     <= rid_d;
            rresp_o   <= rresp_d;
            // Synchronous array read: a same-cycle write to this word lands
            // after this sample, so the beat carries the old contents.
            if (rd_load) rdata_o <= in_range(rd_addr) ? mem[slot(rd_addr)] : 32'd0;
        end
    end

    // Burst payload latches need no reset; they are qualified by the FSMs.
    always_ff @(posedge clk) begin
        wid_q  <= wid_d;
        waddr  <= waddr_d;
        wlen   <= wlen_d;
        wfixed <= wfixed_d;
        raddr  <= raddr_d;
        rlen   <= rlen_d;
        rfixed <= rfixed_d;
        rbad   <= rbad_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) mem[slot(waddr)][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//   Directed bench for axi_sram_slave. Stimulus tasks push expected B and R
//   responses into queues; independent monitors pop and compare on every
//   handshake and check that stalled valid/payload stay stable.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;
    localparam int DEPTH = 4096;
    localparam int ID_W  = 4;

    logic clk, rst_n;
    logic [ID_W-1:0] awid, wid, bid, arid, rid;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0] awlen, wstrb, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;

    axi_sram_slave #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
        .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
        .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
        .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
        .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
        .rvalid_o(rvalid), .rready_i(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
    rexp_t rq[$];
    bexp_t bq[$];
    int total = 0;
    int bad = 0;
    int rmode = 0;
    int bmode = 0;
    bit chk_stream = 1'b0;
    logic [31:0] wd [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL %s: no handshake within bound (got 0, expected 1)", nm);
    endtask

    // Ready drivers: held high in mode 0, random in mode 1.
    initial begin
        rready = 1'b0;
        bready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            bready = (bmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    // R monitor
    rexp_t r_sv;
    bit r_hold = 1'b0;
    bit r_inburst = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            r_hold = 1'b0;
            r_inburst = 1'b0;
        end else begin
            if (r_hold) begin
                check("r_stall_valid", 32'(rvalid), 32'd1);
                check("r_stall_data", rdata, r_sv.data);
                check("r_stall_meta", {26'd0, rid, rresp, rlast}, {26'd0, r_sv.id, r_sv.resp, r_sv.last});
            end
            if (chk_stream && r_inburst) check("r_no_bubble", 32'(rvalid), 32'd1);
            r_hold = 1'b0;
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL r_unexpected: got beat %h, expected none", rdata);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    check("rid", 32'(rid), 32'(e.id));
                    check("rdata", rdata, e.data);
                    check("rresp", 32'(rresp), 32'(e.resp));
                    check("rlast", 32'(rlast), 32'(e.last));
                end
                r_inburst = !rlast;
            end else if (rvalid) begin
                r_hold = 1'b1;
                r_sv.id = rid; r_sv.data = rdata; r_sv.resp = rresp; r_sv.last = rlast;
            end
        end
    end

    // B monitor
    bexp_t b_sv;
    bit b_hold = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            b_hold = 1'b0;
        end else begin
            if (b_hold) begin
                check("b_stall_valid", 32'(bvalid), 32'd1);
                check("b_stall_meta", {26'd0, bid, bresp}, {26'd0, b_sv.id, b_sv.resp});
            end
            b_hold = 1'b0;
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected: got resp %0d, expected none", bresp);
                end else begin
                    bexp_t e;
                    e = bq.pop_front();
                    check("bid", 32'(bid), 32'(e.id));
                    check("bresp", 32'(bresp), 32'(e.resp));
                end
            end else if (bvalid) begin
                b_hold = 1'b1;
                b_sv.id = bid; b_sv.resp = bresp;
            end
        end
    end

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        awid = id; awaddr = a; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!awready && n < 500);
        if (!awready) begin tmo("aw_handshake"); awvalid = 1'b0; return; end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        arid = id; araddr = a; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!arready && n < 500);
        if (!arready) begin tmo("ar_handshake"); arvalid = 1'b0; return; end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic l, input int gap);
        int n = 0;
        wvalid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!wready && n < 500);
        if (!wready) begin tmo("w_handshake"); wvalid = 1'b0; return; end
        @(posedge clk);
        #1;
        wvalid = 1'b0;
    endtask

    // Full write burst of data wd[0..len]; lastbeat < 0 means wlast on the true last beat.
    task automatic wr_burst(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb,
                            input int lastbeat, input int gapmax, input logic [1:0] eresp);
        int lb;
        bexp_t e;
        lb = (lastbeat < 0) ? int'(len) : lastbeat;
        e.id = id; e.resp = eresp;
        bq.push_back(e);
        aw_send(id, a, len, burst, size);
        for (int i = 0; i <= int'(len); i++)
            wbeat(wd[i], strb, (i == lb), (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
    endtask

    task automatic push_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
        rexp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        rq.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 3000) begin @(negedge clk); n++; end
        check("queues_drained", 32'(rq.size() + bq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_awready"}, 32'(awready), 32'd0);
        check({tag, "_wready"}, 32'(wready), 32'd0);
        check({tag, "_bvalid"}, 32'(bvalid), 32'd0);
        check({tag, "_arready"}, 32'(arready), 32'd0);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        check({tag, "_rlast"}, 32'(rlast), 32'd0);
        check({tag, "_bresp_rresp"}, {28'd0, bresp, rresp}, 32'd0);
        check({tag, "_bid_rid"}, {24'd0, bid, rid}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b0;
        @(negedge clk);
        check("awready_before_edge", 32'(awready), 32'd0);
        @(posedge clk);
        #1;
        check("awready_after_release", 32'(awready), 32'd1);
        check("arready_after_release", 32'(arready), 32'd1);

        // Single write then read
        wd[0] = 32'hDEADBEEF;
        wr_burst(4'd3, 32'h100, 4'd0, 2'b01, 3'b010, 4'hF, -1, 0, 2'b00);
        wait_drain();
        push_r(4'd5, 32'hDEADBEEF, 2'b00, 1'b1);
        ar_send(4'd5, 32'h100, 4'd0, 2'b01, 3'b010);
        wait_drain();

        // 16-beat INCR write and streamed read-back
        for (int i = 0; i < 16; i++) wd[i] = i * 32'h11111111;
        wr_burst(4'd1, 32'h1000, 4'd15, 2'b01, 3'b010, 4'hF, -1, 0, 2'b00);
        wait_drain();
        for (int i = 0; i < 16; i++) push_r(4'd2, i * 32'h11111111, 2'b00, i == 15);
        chk_stream = 1'b1;
        ar_send(4'd2, 32'h1000, 4'd15, 2'b01, 3'b010);
        wait_drain();
        chk_stream = 1'b0;

        // Strobes
        wd[0] = 32'hFFFFFFFF;
        wr_burst(4'd4, 32'h300, 4'd0, 2'b01, 3'b010, 4'hF, -1, 0, 2'b00);
        wd[0] = 32'h12345678;
        wr_burst(4'd4, 32'h300, 4'd0, 2'b01, 3'b010, 4'b0101, -1, 0, 2'b00);
        wait_drain();
        push_r(4'd6, 32'hFF34FF78, 2'b00, 1'b1);
        ar_send(4'd6, 32'h300, 4'd0, 2'b01, 3'b010);
        wait_drain();

        // FIXED burst: last beat wins
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        wr_burst(4'd8, 32'h200, 4'd3, 2'b00, 3'b010, 4'hF, -1, 0, 2'b00);
        wait_drain();
        push_r(4'd8, 32'd4, 2'b00, 1'b1);
        ar_send(4'd8, 32'h200, 4'd0, 2'b01, 3'b010);
        wait_drain();

        // Write errors: early wlast, out of range, illegal size
        wr_burst(4'd9, 32'h400, 4'd3, 2'b01, 3'b010, 4'hF, 2, 0, 2'b10);
        wd[0] = 32'h0BAD0BAD;
        wr_burst(4'd10, DEPTH * 4, 4'd0, 2'b01, 3'b010, 4'hF, -1, 0, 2'b10);
        wr_burst(4'd11, 32'h500, 4'd0, 2'b01, 3'b011, 4'hF, -1, 0, 2'b10);
        wd[0] = 32'hCAFEF00D;
        wr_burst(4'd12, (DEPTH - 1) * 4, 4'd0, 2'b01, 3'b010, 4'hF, -1, 0, 2'b00);
        wait_drain();

        // Read errors
        push_r(4'd13, 32'd0, 2'b10, 1'b1);
        ar_send(4'd13, DEPTH * 4, 4'd0, 2'b01, 3'b010);
        push_r(4'd14, 32'hCAFEF00D, 2'b00, 1'b0);
        push_r(4'd14, 32'd0, 2'b10, 1'b1);
        ar_send(4'd14, (DEPTH - 1) * 4, 4'd1, 2'b01, 3'b010);
        push_r(4'd15, 32'hDEADBEEF, 2'b10, 1'b1);
        ar_send(4'd15, 32'h100, 4'd0, 2'b01, 3'b011);
        wait_drain();

        // Concurrent write and read with random backpressure
        rmode = 1;
        bmode = 1;
        for (int i = 0; i < 16; i++) wd[i] = 32'h5A000000 + 32'(i);
        for (int i = 0; i < 16; i++) push_r(4'd9, i * 32'h11111111, 2'b00, i == 15);
        fork
            wr_burst(4'd7, 32'h2000, 4'd15, 2'b01, 3'b010, 4'hF, -1, 2, 2'b00);
            ar_send(4'd9, 32'h1000, 4'd15, 2'b01, 3'b010);
        join
        wait_drain();
        rmode = 0;
        bmode = 0;
        for (int i = 0; i < 16; i++) push_r(4'd3, 32'h5A000000 + 32'(i), 2'b00, i == 15);
        ar_send(4'd3, 32'h2000, 4'd15, 2'b01, 3'b010);
        wait_drain();

        // Reset after 5 of 16 write beats
        aw_send(4'd6, 32'h1000, 4'd15, 2'b01, 3'b010);
        for (int i = 0; i < 5; i++) wbeat(32'hA0000000 + 32'(i), 4'hF, 1'b0, 0);
        check("wready_mid_burst", 32'(wready), 32'd1);
        rst_n = 1'b1;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("awready_release_low", 32'(awready), 32'd0);
        @(posedge clk);
        #1;
        check("awready_release_high", 32'(awready), 32'd1);
        for (int i = 0; i < 16; i++)
            push_r(4'd1, (i < 5) ? 32'hA0000000 + 32'(i) : i * 32'h11111111, 2'b00, i == 15);
        ar_send(4'd1, 32'h1000, 4'd15, 2'b01, 3'b010);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
